// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared codes and helpers for hazard_fwd_ctrl
// Purpose: result-source codes, Tuse "unused" marker, forwarding mux select
//          codes for the D/E/M muxes, shadow stage record and Tnew helpers.
// Ports:   none (package).
package hazard_pkg;

  typedef enum logic [1:0] {
    SRC_PC8  = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_XALU = 2'd2,
    SRC_DM   = 2'd3
  } src_t;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D-stage forwarding mux
  localparam logic [2:0] SEL_D_RF     = 3'd0;
  localparam logic [2:0] SEL_D_PC8_E  = 3'd1;
  localparam logic [2:0] SEL_D_ALU_M  = 3'd2;
  localparam logic [2:0] SEL_D_PC8_M  = 3'd3;
  localparam logic [2:0] SEL_D_GRF_WD = 3'd4;
  localparam logic [2:0] SEL_D_XALU_M = 3'd5;

  // E-stage forwarding mux
  localparam logic [2:0] SEL_E_PIPE   = 3'd0;
  localparam logic [2:0] SEL_E_ALU_M  = 3'd1;
  localparam logic [2:0] SEL_E_PC8_M  = 3'd2;
  localparam logic [2:0] SEL_E_GRF_WD = 3'd3;
  localparam logic [2:0] SEL_E_XALU_M = 3'd4;

  // M-stage store-data mux
  localparam logic SEL_M_PIPE   = 1'b0;
  localparam logic SEL_M_GRF_WD = 1'b1;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    src_t       src;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  // Cycles until the result exists, counted from E entry.
  function automatic logic [1:0] init_tnew(input src_t src);
    logic [1:0] t;
    t = 2'd0;
    case (src)
      SRC_PC8:  t = 2'd0;
      SRC_ALU:  t = 2'd1;
      SRC_XALU: t = 2'd1;
      SRC_DM:   t = 2'd2;
      default:  t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// rtl/md_busy_ctr.sv - mult/div busy down counter
// Purpose: loads MULT_CYCLES or DIV_CYCLES when a start leaves E, then counts
//          down to zero; busy while the count is non-zero.
// Ports:   clk, reset (sync, active-high), start_i (start leaving E this
//          cycle), kind_i (0 mult, 1 div), busy_o.
module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic kind_i,
  output logic busy_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = kind_i ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard detection and forwarding control, 5-stage MIPS
// Purpose: shadow pipeline of E/M/W destination, Tnew and source; compares
//          against D-stage rs/rt Tuse to produce forwarding selects and stall;
//          owns the mult/div busy counter. Optional STALL_CNT_EN adds a 32-bit
//          stall cycle counter output stall_cnt.
// Ports:   clk, reset (sync, active-high); D inputs rs_d, rt_d, tuse_rs_d,
//          tuse_rt_d, a3_d, src_d, md_op_d, md_start_d, md_kind_d; outputs
//          stall, sel_rsd/sel_rtd (D mux), sel_rse/sel_rte (E mux),
//          sel_rtm (M mux), md_busy[, stall_cnt].
module hazard_fwd_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] src_d,
  input  logic       md_op_d,
  input  logic       md_start_d,
  input  logic       md_kind_d,
  output logic       stall,
  output logic [2:0] sel_rsd,
  output logic [2:0] sel_rtd,
  output logic [2:0] sel_rse,
  output logic [2:0] sel_rte,
  output logic       sel_rtm,
  output logic       md_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  import hazard_pkg::*;

  stage_t     e_q, e_d, m_q, m_d;
  logic       md_start_e_q, md_start_e_d;
  logic       md_kind_e_q, md_kind_e_d;
  logic [4:0] w_a3_q;
  src_t       w_src_q;  // W Tnew is always 0, so it is not stored

  logic hazard_stall, md_stall;

  // Register 0 is never a dependency.
  function automatic logic hit(input logic [4:0] a3, input logic [4:0] r);
    return (r != 5'd0) && (a3 == r);
  endfunction

  // Only the nearest matching stage is considered; if its result is not ready
  // the register file value is selected and the stall logic decides.
  function automatic logic [2:0] fwd_d_sel(input logic [4:0] r, input stage_t e,
                                           input stage_t m, input logic [4:0] w_a3);
    logic [2:0] sel;
    sel = SEL_D_RF;
    if (hit(e.a3, r)) begin
      if (e.tnew == 2'd0 && e.src == SRC_PC8) sel = SEL_D_PC8_E;
    end else if (hit(m.a3, r)) begin
      if (m.tnew == 2'd0) begin
        case (m.src)
          SRC_ALU:  sel = SEL_D_ALU_M;
          SRC_PC8:  sel = SEL_D_PC8_M;
          SRC_XALU: sel = SEL_D_XALU_M;
          default:  sel = SEL_D_RF;
        endcase
      end
    end else if (hit(w_a3, r)) begin
      sel = SEL_D_GRF_WD;
    end
    return sel;
  endfunction

  function automatic logic [2:0] fwd_e_sel(input logic [4:0] r, input stage_t m,
                                           input logic [4:0] w_a3);
    logic [2:0] sel;
    sel = SEL_E_PIPE;
    if (hit(m.a3, r)) begin
      if (m.tnew == 2'd0) begin
        case (m.src)
          SRC_ALU:  sel = SEL_E_ALU_M;
          SRC_PC8:  sel = SEL_E_PC8_M;
          SRC_XALU: sel = SEL_E_XALU_M;
          default:  sel = SEL_E_PIPE;
        endcase
      end
    end else if (hit(w_a3, r)) begin
      sel = SEL_E_GRF_WD;
    end
    return sel;
  endfunction

  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input stage_t e, input stage_t m);
    logic s;
    s = 1'b0;
    if (tuse != TUSE_NONE) begin
      if (hit(e.a3, r))      s = (e.tnew > tuse);
      else if (hit(m.a3, r)) s = (m.tnew > tuse);
    end
    return s;
  endfunction

  assign hazard_stall = src_stall(rs_d, tuse_rs_d, e_q, m_q)
                      | src_stall(rt_d, tuse_rt_d, e_q, m_q);
  // A start still in E has not loaded the counter yet, so it blocks too.
  assign md_stall     = md_op_d & (md_busy | md_start_e_q);
  assign stall        = hazard_stall | md_stall;

  assign sel_rsd = fwd_d_sel(rs_d, e_q, m_q, w_a3_q);
  assign sel_rtd = fwd_d_sel(rt_d, e_q, m_q, w_a3_q);
  assign sel_rse = fwd_e_sel(e_q.rs, m_q, w_a3_q);
  assign sel_rte = fwd_e_sel(e_q.rt, m_q, w_a3_q);
  assign sel_rtm = hit(w_a3_q, m_q.rt) ? SEL_M_GRF_WD : SEL_M_PIPE;

  always_comb begin
    // Stalled D inserts a full bubble into E.
    e_d          = '0;
    md_start_e_d = 1'b0;
    md_kind_e_d  = 1'b0;
    if (!stall) begin
      e_d.a3       = a3_d;
      e_d.src      = src_t'(src_d);
      e_d.tnew     = init_tnew(src_t'(src_d));
      e_d.rs       = rs_d;
      e_d.rt       = rt_d;
      md_start_e_d = md_start_d;
      md_kind_e_d  = md_kind_d;
    end
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= '0;
      m_q          <= '0;
      w_a3_q       <= 5'd0;
      w_src_q      <= SRC_PC8;
      md_start_e_q <= 1'b0;
      md_kind_e_q  <= 1'b0;
    end else begin
      e_q          <= e_d;
      m_q          <= m_d;
      w_a3_q       <= m_q.a3;
      w_src_q      <= m_q.src;
      md_start_e_q <= md_start_e_d;
      md_kind_e_q  <= md_kind_e_d;
    end
  end

  // Shadow fields kept for pipeline visibility but not consumed here.
  logic unused_shadow;
  assign unused_shadow = ^{w_src_q, m_q.rs};

  md_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start_i(md_start_e_q),
    .kind_i (md_kind_e_q),
    .busy_o (md_busy)
  );

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
